// File: rtl/board_pkg.sv
// Shared definitions for the tile board write path.
// Board geometry is 40 columns x 32 rows of 5-bit tile IDs, stored row-major
// at address row*40+col in an 11-bit address space.
// Contents: geometry constants, FSM state enum, arbitration owner enum, tile type.
package board_pkg;

  localparam int BOARD_COLS   = 40;
  localparam int BOARD_ROWS   = 32;
  localparam int BOARD_CELLS  = BOARD_COLS * BOARD_ROWS;
  localparam int TILE_W       = 5;
  localparam int BOARD_ADDR_W = 11;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  // Which requester wins the next contended cycle.
  typedef enum logic {
    OWN_FILL = 1'b0,
    OWN_CPU  = 1'b1
  } owner_t;

  typedef logic [TILE_W-1:0] tile_t;

endpackage

// File: rtl/board_fill_seq.sv
// Fill engine for the tile board: walks addresses 0..CELLS-1 with one latched
// tile value, advancing one cell each cycle the arbiter grants it.
// Ports:
//   clock, reset      system clock, synchronous active-low reset
//   fill_start        single-cycle fill command (ignored while a fill runs)
//   fill_tile         fill value, latched with fill_start
//   advance           arbiter granted the current fill cell this cycle
//   active            engine is in FILL (combinational view of the state)
//   fill_addr         address of the cell offered to the arbiter
//   fill_value        latched fill tile
//   fill_busy         registered FILL indicator
//   fill_done         one-cycle pulse once the last cell has been granted
module board_fill_seq #(
  parameter int CELLS  = board_pkg::BOARD_CELLS,
  parameter int ADDR_W = board_pkg::BOARD_ADDR_W,
  parameter int TILE_W = board_pkg::TILE_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              fill_start,
  input  logic [TILE_W-1:0] fill_tile,
  input  logic              advance,
  output logic              active,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [TILE_W-1:0] fill_value,
  output logic              fill_busy,
  output logic              fill_done
);
  import board_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);

  state_t            state;
  logic [ADDR_W-1:0] counter;
  logic [TILE_W-1:0] tile;

  assign active     = (state == FILL);
  assign fill_addr  = counter;
  assign fill_value = tile;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      counter   <= '0;
      tile      <= '0;
      fill_busy <= 1'b0;
      fill_done <= 1'b0;
    end else begin
      fill_done <= 1'b0;
      case (state)
        IDLE: begin
          if (fill_start) begin
            state     <= FILL;
            tile      <= fill_tile;
            counter   <= '0;
            fill_busy <= 1'b1;
          end
        end
        FILL: begin
          // A second fill_start here is deliberately not looked at, so the
          // latched tile stays put for the whole sweep.
          if (advance) begin
            if (counter == LAST_CELL) begin
              state     <= IDLE;
              counter   <= '0;
              fill_busy <= 1'b0;
              fill_done <= 1'b1;
            end else begin
              counter <= counter + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/board_write_ctrl.sv
// Owner of the single tile board RAM write port. Arbitrates between single
// cell writes from game logic and the internal fill engine, then registers
// the winner onto the RAM write port (one cycle latency).
// Optional build macro: BOARD_WRITE_VBLANK_GATE_EN -- when defined, grants of
// either kind are only made while vblank is high; otherwise vblank is ignored.
// Ports:
//   clock, reset          system clock, synchronous active-low reset
//   wr_valid / wr_ready   game-logic write handshake (wr_ready combinational)
//   wr_col, wr_row        target cell; out-of-range cells are accepted and dropped
//   wr_tile               tile ID to write
//   fill_start, fill_tile fill command and value
//   fill_busy, fill_done  fill engine status
//   vblank                vertical-blank indicator (gate feature only)
//   board_wraddress, board_data, board_wren   RAM write port
module board_write_ctrl #(
  parameter int COLS   = board_pkg::BOARD_COLS,
  parameter int ROWS   = board_pkg::BOARD_ROWS,
  parameter int TILE_W = board_pkg::TILE_W,
  parameter int ADDR_W = board_pkg::BOARD_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [5:0]        wr_col,
  input  logic [4:0]        wr_row,
  input  logic [TILE_W-1:0] wr_tile,
  input  logic              fill_start,
  input  logic [TILE_W-1:0] fill_tile,
  output logic              fill_busy,
  output logic              fill_done,
  input  logic              vblank,
  output logic [ADDR_W-1:0] board_wraddress,
  output logic [TILE_W-1:0] board_data,
  output logic              board_wren
);
  import board_pkg::*;

  // Row-major address, formed at 32 bits and then cut to the RAM width.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [4:0] row,
                                                  input logic [5:0] col);
    logic [31:0] full;
    full = 32'(row) * 32'(COLS) + 32'(col);
    return full[ADDR_W-1:0];
  endfunction

  function automatic logic cell_in_range(input logic [4:0] row,
                                         input logic [5:0] col);
    return (32'(col) < 32'(COLS)) && (32'(row) < 32'(ROWS));
  endfunction

  logic              gate_open;
  logic              fill_active;
  logic [ADDR_W-1:0] fill_addr;
  logic [TILE_W-1:0] fill_value;
  logic              cpu_grant;
  logic              fill_grant;
  owner_t            token;

  logic [ADDR_W-1:0] wraddr_p1;
  logic [TILE_W-1:0] wdata_p1;
  logic              wren_p1;

`ifdef BOARD_WRITE_VBLANK_GATE_EN
  assign gate_open = vblank;
`else
  logic unused_vblank;
  assign unused_vblank = vblank;
  assign gate_open     = 1'b1;
`endif

  board_fill_seq #(
    .CELLS  (COLS * ROWS),
    .ADDR_W (ADDR_W),
    .TILE_W (TILE_W)
  ) u_fill_seq (
    .clock      (clock),
    .reset      (reset),
    .fill_start (fill_start),
    .fill_tile  (fill_tile),
    .advance    (fill_grant),
    .active     (fill_active),
    .fill_addr  (fill_addr),
    .fill_value (fill_value),
    .fill_busy  (fill_busy),
    .fill_done  (fill_done)
  );

  // wr_ready does not look at wr_valid: it says whether a cpu request would
  // win this cycle, so it can be high with no request pending.
  assign wr_ready   = gate_open && (!fill_active || (token == OWN_CPU));
  assign cpu_grant  = wr_valid && wr_ready;
  assign fill_grant = gate_open && fill_active && !cpu_grant;

  // The token only changes on a grant, so contention alternates strictly and
  // an out-of-range (dropped) cpu write still hands the next turn to the fill.
  always_ff @(posedge clock) begin
    if (!reset) begin
      token <= OWN_FILL;
    end else if (cpu_grant) begin
      token <= OWN_FILL;
    end else if (fill_grant) begin
      token <= OWN_CPU;
    end
  end

  // Stage p1: registered RAM write port
  always_ff @(posedge clock) begin
    if (!reset) begin
      wren_p1   <= 1'b0;
      wraddr_p1 <= '0;
      wdata_p1  <= '0;
    end else if (cpu_grant) begin
      wren_p1 <= cell_in_range(wr_row, wr_col);
      if (cell_in_range(wr_row, wr_col)) begin
        wraddr_p1 <= cell_addr(wr_row, wr_col);
        wdata_p1  <= wr_tile;
      end
    end else if (fill_grant) begin
      wren_p1   <= 1'b1;
      wraddr_p1 <= fill_addr;
      wdata_p1  <= fill_value;
    end else begin
      wren_p1 <= 1'b0;
    end
  end

  assign board_wraddress = wraddr_p1;
  assign board_data      = wdata_p1;
  assign board_wren      = wren_p1;

endmodule

// File: tb/tb_board_write_ctrl.sv
// Scoreboard bench for board_write_ctrl: stimulus pushes the expected RAM
// writes into a queue, a negedge monitor pops and compares every board_wren.
module tb_board_write_ctrl;

  localparam int CELLS = 1280;

  logic        clock = 1'b0;
  logic        reset;
  logic        wr_valid;
  logic        wr_ready;
  logic [5:0]  wr_col;
  logic [4:0]  wr_row;
  logic [4:0]  wr_tile;
  logic        fill_start;
  logic [4:0]  fill_tile;
  logic        fill_busy;
  logic        fill_done;
  logic        vblank;
  logic [10:0] board_wraddress;
  logic [4:0]  board_data;
  logic        board_wren;

  typedef struct packed {
    logic [10:0] addr;
    logic [4:0]  data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   wren_cnt = 0;
  int   done_cnt = 0;

  board_write_ctrl dut (
    .clock           (clock),
    .reset           (reset),
    .wr_valid        (wr_valid),
    .wr_ready        (wr_ready),
    .wr_col          (wr_col),
    .wr_row          (wr_row),
    .wr_tile         (wr_tile),
    .fill_start      (fill_start),
    .fill_tile       (fill_tile),
    .fill_busy       (fill_busy),
    .fill_done       (fill_done),
    .vblank          (vblank),
    .board_wraddress (board_wraddress),
    .board_data      (board_data),
    .board_wren      (board_wren)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic push(input int addr, input int data);
    exp_t e;
    e.addr = 11'(addr);
    e.data = 5'(data);
    sb.push_back(e);
  endtask

  // Monitor: every RAM write must match the head of the scoreboard.
  always @(negedge clock) begin
    if (board_wren === 1'b1) begin
      wren_cnt++;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_wren: got addr %0d data %0d, required no write",
                 int'(board_wraddress), int'(board_data));
      end else begin
        mon_e = sb.pop_front();
        check("wr_addr", int'(board_wraddress), int'(mon_e.addr));
        check("wr_data", int'(board_data), int'(mon_e.data));
      end
    end
    if (fill_done === 1'b1) done_cnt++;
  end

  task automatic cpu_write(input int col, input int row, input int tile,
                           input bit in_range, input string name);
    bit ok;
    ok = 1'b0;
    @(posedge clock); #1;
    wr_valid = 1'b1;
    wr_col   = 6'(col);
    wr_row   = 5'(row);
    wr_tile  = 5'(tile);
    for (int n = 0; n < 20; n++) begin
      @(negedge clock);
      if (wr_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_ready"}, int'(ok), 1);
    if (in_range) push(row * 40 + col, tile);
    @(posedge clock); #1;
    wr_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  cyc;
    int  stall;
    int  max_stall;
    int  base;
    bit  got;

    // Reset held with requests pending: nothing may reach the RAM port.
    reset      = 1'b0;
    wr_valid   = 1'b1;
    wr_col     = 6'd5;
    wr_row     = 5'd2;
    wr_tile    = 5'd7;
    fill_start = 1'b1;
    fill_tile  = 5'd2;
    vblank     = 1'b1;
    repeat (3) begin
      @(negedge clock);
      check("rst_wren", int'(board_wren), 0);
      check("rst_addr", int'(board_wraddress), 0);
      check("rst_data", int'(board_data), 0);
      check("rst_busy", int'(fill_busy), 0);
      check("rst_done", int'(fill_done), 0);
    end

    // Release with the single write still presented: col 5, row 2 -> 85.
    reset      = 1'b1;
    fill_start = 1'b0;
    check("single_ready", int'(wr_ready), 1);
    push(85, 7);
    @(posedge clock); #1;
    wr_valid = 1'b0;
    @(negedge clock);
    check("busy_after_rst", int'(fill_busy), 0);

    // Full fill with tile 3; a mid-fill start with tile 1 must be ignored.
    @(posedge clock); #1;
    fill_start = 1'b1;
    fill_tile  = 5'd3;
    for (int i = 0; i < CELLS; i++) push(i, 3);
    @(posedge clock); #1;
    fill_start = 1'b0;
    base = wren_cnt;
    cyc  = 0;
    got  = 1'b0;
    for (int n = 0; n < 1400; n++) begin
      @(negedge clock);
      if (n == 0) check("fill_busy_rise", int'(fill_busy), 1);
      if (n == 100) begin
        fill_start = 1'b1;
        fill_tile  = 5'd1;
      end
      if (n == 101) fill_start = 1'b0;
      if (fill_done) begin
        got = 1'b1;
        break;
      end
      cyc++;
    end
    check("fill_done_seen", int'(got), 1);
    check("fill_cycles", cyc, 1280);
    check("fill_busy_fall", int'(fill_busy), 0);
    @(negedge clock);
    check("fill_wren_count", wren_cnt - base, 1280);
    check("fill_done_pulse", int'(fill_done), 0);
    check("fill_done_once", done_cnt, 1);

    // Out-of-range column: handshake completes, nothing written.
    cpu_write(40, 0, 20, 1'b0, "oor");
    // Last valid cell.
    cpu_write(39, 31, 31, 1'b1, "last_cell");
    repeat (3) @(negedge clock);

    // Contention: fill tile 6 against a held write of tile 9 at cell 0.
    @(posedge clock); #1;
    fill_start = 1'b1;
    fill_tile  = 5'd6;
    wr_valid   = 1'b1;
    wr_col     = 6'd0;
    wr_row     = 5'd0;
    wr_tile    = 5'd9;
    push(0, 9);
    for (int i = 0; i < CELLS; i++) begin
      push(i, 6);
      push(0, 9);
    end
    @(negedge clock);
    check("sim_start_ready", int'(wr_ready), 1);
    @(posedge clock); #1;
    fill_start = 1'b0;
    cyc       = 0;
    stall     = 0;
    max_stall = 0;
    got       = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clock);
      if (!wr_ready) stall++;
      else stall = 0;
      if (stall > max_stall) max_stall = stall;
      if (fill_done) begin
        got = 1'b1;
        break;
      end
      cyc++;
    end
    check("cont_done_seen", int'(got), 1);
    check("cont_cycles", cyc, 2559);
    check("cont_max_stall", max_stall, 1);
    check("cont_ready_after", int'(wr_ready), 1);
    @(posedge clock); #1;
    wr_valid = 1'b0;
    repeat (2) @(negedge clock);
    check("cont_sb_empty", sb.size(), 0);
    check("cont_done_count", done_cnt, 2);

    // Reset in the middle of a fill after five cells have been granted.
    @(posedge clock); #1;
    fill_start = 1'b1;
    fill_tile  = 5'd12;
    for (int i = 0; i < 5; i++) push(i, 12);
    @(posedge clock); #1;
    fill_start = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("abort_wren", int'(board_wren), 0);
    check("abort_busy", int'(fill_busy), 0);
    check("abort_done", int'(fill_done), 0);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("abort_sb_empty", sb.size(), 0);
    check("abort_no_done", done_cnt, 2);

`ifdef BOARD_WRITE_VBLANK_GATE_EN
    // Gate closed: the write waits, then issues once vblank opens.
    @(posedge clock); #1;
    vblank   = 1'b0;
    wr_valid = 1'b1;
    wr_col   = 6'd1;
    wr_row   = 5'd1;
    wr_tile  = 5'd4;
    for (int n = 0; n < 10; n++) begin
      @(negedge clock);
      check("gate_closed_ready", int'(wr_ready), 0);
    end
    vblank = 1'b1;
    #1;
    check("gate_open_ready", int'(wr_ready), 1);
    push(41, 4);
    @(posedge clock); #1;
    wr_valid = 1'b0;
    repeat (2) @(negedge clock);
`else
    // Without the gate, vblank low must not hold back a write.
    vblank = 1'b0;
    cpu_write(1, 1, 4, 1'b1, "no_gate");
    repeat (2) @(negedge clock);
    vblank = 1'b1;
`endif

    check("final_sb_empty", sb.size(), 0);
    check("final_done_count", done_cnt, 2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
